led_uart_gen: RTL and testbench

LED_UART_GEN -- requirements
Module: led_uart_gen

---
 rtl/led_uart_gen.sv | 148 ++++++++++++++
 tb/tb_led_uart_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_uart_gen.sv
// LED counter advanced by a run-gated tick divider; each new value is sent as one UART frame.
// Optional: define LED_UART_PARITY_EN to add an even-parity bit (11-bit frame).

module led_uart_gen #(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned TICK_DIV = 12000000,
  parameter int unsigned BAUD_DIV = 104
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             clr_ovr,
  output logic [CNT_W-1:0] led,
  output logic             tx,
  output logic             tx_busy,
  output logic             overrun
);

  localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef LED_UART_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t            r_state;
  logic [DIV_W-1:0]  r_div;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic [CNT_W-1:0]  r_led;
  logic              r_tx;
  logic              r_busy;
  logic              r_ovr;
`ifdef LED_UART_PARITY_EN
  logic              r_par;
`endif

  logic              w_tick;
  logic              w_baud_end;
  logic [CNT_W-1:0]  w_led_next;

  assign w_tick     = run && (r_div == DIV_W'(TICK_DIV - 1));
  assign w_baud_end = (r_baud == BAUD_W'(BAUD_DIV - 1));
  assign w_led_next = r_led + CNT_W'(1);

  assign led     = r_led;
  assign tx      = r_tx;
  assign tx_busy = r_busy;
  assign overrun = r_ovr;

  // Tick divider, LED counter and sticky overrun (a tick while busy drops the frame)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
      r_led <= '0;
      r_ovr <= 1'b0;
    end else begin
      if (run) r_div <= w_tick ? '0 : r_div + DIV_W'(1);
      if (w_tick) r_led <= w_led_next;
      if (w_tick && r_busy) r_ovr <= 1'b1;
      else if (clr_ovr)     r_ovr <= 1'b0;
    end
  end

  // UART transmitter; every non-idle state lasts BAUD_DIV clocks per bit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
`ifdef LED_UART_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      if (r_state != S_IDLE) r_baud <= w_baud_end ? '0 : r_baud + BAUD_W'(1);
      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_state <= S_START;
            r_shift <= 8'(w_led_next);
`ifdef LED_UART_PARITY_EN
            r_par   <= ^w_led_next;
`endif
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_baud  <= '0;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_state <= S_DATA;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            if (r_bit == 3'd7) begin
`ifdef LED_UART_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= r_par;
`else
              r_state <= S_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_tx    <= r_shift[0];
              r_shift <= {1'b0, r_shift[7:1]};
            end
          end
        end
`ifdef LED_UART_PARITY_EN
        S_PARITY: begin
          if (w_baud_end) begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_baud_end) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_uart_gen.sv
// Bench for led_uart_gen: two instances (tick 64 and tick 16, baud 4) checked every cycle
// against a frame-timeline model, plus hand-computed frame and overrun expectations.

module tb_led_uart_gen;

  localparam int unsigned CNT_W = 4;
  localparam int TD_A = 64;
  localparam int TD_B = 16;
  localparam int BD   = 4;
`ifdef LED_UART_PARITY_EN
  localparam int NB = 11;
  localparam logic [10:0] EXP_F01 = 11'b11000000010;
  localparam logic [10:0] EXP_F00 = 11'b10000000000;
  localparam logic [10:0] EXP_F03 = 11'b10000000110;
`else
  localparam int NB = 10;
  localparam logic [10:0] EXP_F01 = 11'b01000000010;
  localparam logic [10:0] EXP_F00 = 11'b01000000000;
  localparam logic [10:0] EXP_F03 = 11'b01000000110;
`endif
  localparam int FRAME = NB * BD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, run, clr_ovr;
  logic [CNT_W-1:0] led_a, led_b;
  logic             tx_a, tx_b, busy_a, busy_b, ovr_a, ovr_b;

  led_uart_gen #(.CNT_W(CNT_W), .TICK_DIV(TD_A), .BAUD_DIV(BD)) u_a (
    .clk(clk), .reset(reset), .run(run), .clr_ovr(clr_ovr),
    .led(led_a), .tx(tx_a), .tx_busy(busy_a), .overrun(ovr_a)
  );

  led_uart_gen #(.CNT_W(CNT_W), .TICK_DIV(TD_B), .BAUD_DIV(BD)) u_b (
    .clk(clk), .reset(reset), .run(run), .clr_ovr(clr_ovr),
    .led(led_b), .tx(tx_b), .tx_busy(busy_b), .overrun(ovr_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per instance a tick count, LED value and the remaining cycles of the frame on the wire
  int          m_div [2];
  int          m_led [2];
  int          m_left[2];
  bit          m_ovr [2];
  logic [10:0] m_bits[2];
  bit          m_valid = 1'b0;
  bit          mb_busy, mb_tick;
  int          mb_td;

  function automatic logic [10:0] make_frame(input int v);
    logic [7:0]  d;
    logic [10:0] f;
    d      = 8'(v);
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef LED_UART_PARITY_EN
    f[9]   = ^d;
`endif
    return f;
  endfunction

  function automatic logic exp_tx(input int i);
    if (m_left[i] == 0) return 1'b1;
    return m_bits[i][(FRAME - m_left[i]) / BD];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      mb_td = (i == 0) ? TD_A : TD_B;
      if (reset) begin
        m_div[i]  = 0;
        m_led[i]  = 0;
        m_left[i] = 0;
        m_ovr[i]  = 1'b0;
      end else begin
        mb_busy = (m_left[i] != 0);
        if (m_left[i] != 0) m_left[i] = m_left[i] - 1;
        mb_tick = run && (m_div[i] == mb_td - 1);
        if (run) m_div[i] = (m_div[i] + 1) % mb_td;
        if (clr_ovr) m_ovr[i] = 1'b0;
        if (mb_tick) begin
          m_led[i] = (m_led[i] + 1) % (1 << CNT_W);
          if (mb_busy) m_ovr[i] = 1'b1;
          else begin
            m_left[i] = FRAME;
            m_bits[i] = make_frame(m_led[i]);
          end
        end
      end
    end
    if (reset) m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("a.led",     32'(led_a),  32'(m_led[0]));
      check("a.tx",      32'(tx_a),   32'(exp_tx(0)));
      check("a.tx_busy", 32'(busy_a), 32'(m_left[0] != 0));
      check("a.overrun", 32'(ovr_a),  32'(m_ovr[0]));
      check("b.led",     32'(led_b),  32'(m_led[1]));
      check("b.tx",      32'(tx_b),   32'(exp_tx(1)));
      check("b.tx_busy", 32'(busy_b), 32'(m_left[1] != 0));
      check("b.overrun", 32'(ovr_b),  32'(m_ovr[1]));
    end
  end

  task automatic wait_busy_a(input int lim, input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < lim && !seen; n++) begin
      @(negedge clk);
      seen = busy_a;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  // Samples the middle of each bit starting at the first busy cycle; counts busy cycles
  task automatic capture_a(output logic [10:0] bits, output int bcnt);
    bits = '0;
    bcnt = 0;
    for (int c = 0; c <= FRAME; c++) begin
      if (c > 0) @(negedge clk);
      if (busy_a) bcnt++;
      if (c < FRAME && (c % BD) == BD / 2) bits[c / BD] = tx_a;
    end
  endtask

  logic [10:0] cap;
  int          bcnt;
  int          prev;
  bit          seen;

  initial begin
    reset = 1'b1; run = 1'b0; clr_ovr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    check("pwr.led",     32'(led_a),  32'd0);
    check("pwr.tx",      32'(tx_a),   32'd1);
    check("pwr.tx_busy", 32'(busy_a), 32'd0);
    check("pwr.overrun", 32'(ovr_a),  32'd0);

    // Overrun on the fast instance: second tick lands 16 clocks into a 40-clock frame
    run = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      seen = ovr_b;
    end
    check("ovr.seen",    32'(seen),   32'd1);
    check("ovr.led",     32'(led_b),  32'd2);
    check("ovr.tx_busy", 32'(busy_b), 32'd1);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    check("ovr.cleared", 32'(ovr_b), 32'd0);

    // First frame on the slow instance carries 0x01
    wait_busy_a(100, "f1.start");
    check("f1.led", 32'(led_a), 32'd1);
    capture_a(cap, bcnt);
    check("f1.frame",    32'(cap),  32'(EXP_F01));
    check("f1.busy_len", 32'(bcnt), 32'(FRAME));

    // Wrap 15 -> 0; that frame carries 0x00
    prev = int'(led_a);
    seen = 1'b0;
    for (int n = 0; n < 1300 && !seen; n++) begin
      @(negedge clk);
      if (led_a == '0) seen = 1'b1;
      else prev = int'(led_a);
    end
    check("wrap.seen",    32'(seen),   32'd1);
    check("wrap.prev",    32'(prev),   32'd15);
    check("wrap.tx_busy", 32'(busy_a), 32'd1);
    capture_a(cap, bcnt);
    check("wrap.frame", 32'(cap), 32'(EXP_F00));

    // Reset during data bit 3 aborts the frame
    wait_busy_a(100, "rst.start");
    repeat (18) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst.tx",      32'(tx_a),   32'd1);
    check("rst.tx_busy", 32'(busy_a), 32'd0);
    check("rst.led",     32'(led_a),  32'd0);
    wait_busy_a(100, "rst.restart");
    check("rst.led1", 32'(led_a), 32'd1);
    capture_a(cap, bcnt);
    check("rst.frame", 32'(cap), 32'(EXP_F01));

    // Dropping run mid-frame lets the frame finish and freezes the counter
    wait_busy_a(100, "run.start");
    check("run.led", 32'(led_a), 32'd2);
    run = 1'b0;
    repeat (60) @(negedge clk);
    check("run.led_hold", 32'(led_a),  32'd2);
    check("run.tx_busy",  32'(busy_a), 32'd0);
    check("run.tx",       32'(tx_a),   32'd1);

    // Frame for led=3 (data 1,1,0,...; parity 0 when enabled)
    run = 1'b1;
    wait_busy_a(100, "f3.start");
    check("f3.led", 32'(led_a), 32'd3);
    capture_a(cap, bcnt);
    check("f3.frame",    32'(cap),  32'(EXP_F03));
    check("f3.busy_len", 32'(bcnt), 32'(FRAME));

    repeat (20) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
